modbus_rtu_rx_framer: RTL and testbench
=======================================

# modbus_rtu_rx_framer

Receive-side Modbus RTU framer: takes the byte stream from the UART receiver, delimits frames by inter-frame silence (t3.5), buffers the frame bytes and checks the CRC-16/MODBUS trailer (poly 0x8005 reflected, i.e. 0xA001; init 0xFFFF; no final XOR). It sits between the UART RX byte strobe and the slave command decoder. It is the checking counterpart of the transmit-side CRC16 generator.

## Interface
- GAP_CYCLES, 200521: consecutive idle clock cycles that end a frame (t3.5 at 50 MHz, 9600 baud).
- MAX_LEN, 256: buffer depth in bytes. This is the maximum frame length including the 2 CRC bytes.
- sys_clk  in  1: system clock. This is the single clock domain.
- rst  in  1: asynchronous, active-high reset.
- rx_data  in  8: received byte. Valid when rx_vld is high.
- rx_vld  in  1: one-cycle byte strobe from the UART RX.
- frame_done  out  1: one-cycle pulse at the end of each frame.
- frame_ok  out  1: the last frame had a valid CRC, length ≥ 4 and no overflow. Held until the next frame_done.
- crc_err  out  1: the last frame's CRC residue was not 0x0000. Held.
- len_err  out  1: the last frame was shorter than 4 bytes or longer than MAX_LEN. Held.
- frame_len  out  9: byte count of the last frame, including CRC, saturating at MAX_LEN. Held.
- busy  out  1: high in SYNC and RECV.
- rd_addr  in  8: buffer read address.
- rd_data  out  8: buffer byte at rd_addr, registered, 1-cycle latency.

## Operation
- States:
  - SYNC: after reset, wait for GAP_CYCLES of silence. Any byte received here restarts the count and is discarded. Silence reached → IDLE.
  - IDLE: waits for the first byte.
  - RECV: collects bytes.
  - DONE: a single cycle; frame_done=1.
- Transitions:
  - IDLE, rx_vld → RECV. The byte is written to address 0, len=1, crc=update(0xFFFF, byte).
  - RECV, rx_vld → the byte is written at address len if len<MAX_LEN, else dropped and ovf set. crc is updated only for stored bytes. len saturates at MAX_LEN.
  - RECV, silence count reaches GAP_CYCLES → DONE. In DONE the status outputs are latched from crc, len and ovf.
  - DONE → IDLE. If rx_vld is high in the DONE cycle, the next state is RECV instead, and that byte is the first byte of a new frame (address 0, len=1).
- CRC update: 8 unrolled steps per byte in one cycle. Each step is crc = crc[0] ? (crc>>1)^0xA001 : crc>>1, after crc ^= {8'h00, byte}. The trailer (low byte first) is included in the running CRC, so a good frame leaves residue 0x0000.
- Status latch:
  - crc_err = (crc != 0)
  - len_err = (len < 4) | ovf
  - frame_ok = ~crc_err & ~len_err
  - frame_len = len
- Silence counter: cleared on every rx_vld, otherwise increments and saturates at GAP_CYCLES. It runs in all states.
- Buffer: single-port write and independent registered read. Contents stay valid from frame_done until the first byte of the next frame overwrites address 0 onward.
- Reset mid-frame: state → SYNC, the partial frame is discarded, no frame_done is issued.

## Timing
- Reset values:
  - state=SYNC, busy=1
  - frame_done=0, frame_ok=0, crc_err=0, len_err=0, frame_len=0, rd_data=0
  - crc=0xFFFF, len=0, ovf=0
- Frame end: last byte accepted at cycle t with no rx_vld in t+1..t+GAP_CYCLES → frame_done=1 at cycle t+GAP_CYCLES+1. Status outputs are valid from that same cycle.
- busy falls in the DONE cycle.
- rd_data reflects rd_addr from the previous cycle.
- A write and a read of the same address in the same cycle return the old data.

## Test plan
- Good frame, with GAP_CYCLES=50 and reset already cleared by a 60-cycle idle.
  - Stimulus: bytes 01 03 00 00 00 01 84 0A, 10 cycles apart.
  - Required: frame_done exactly 51 cycles after byte 0A; frame_ok=1, crc_err=0, len_err=0, frame_len=8.
  - Readback: reading addresses 0..7 returns the same 8 bytes.
- Bad CRC: stimulus is the same frame with the last byte 0x0B. Required: frame_done with crc_err=1, frame_ok=0, frame_len=8.
- Short frame: stimulus is bytes 01 03. Required: len_err=1, frame_ok=0, frame_len=2.
- Overflow, with MAX_LEN=8: stimulus is 10 bytes. Required: len_err=1, frame_len=8, the 9th and 10th bytes are not written, and the CRC is computed over the first 8 bytes only.
- Startup sync: stimulus is a byte 20 cycles after reset and a second byte 30 cycles later. Required: both bytes are discarded, no frame_done, IDLE reached only after 50 silent cycles; a good frame sent afterwards gives frame_ok=1.
- Back-to-back and reset cases:
  - rx_vld asserted in the DONE cycle: it starts a new frame with frame_len counting from 1, and the next good frame passes.
  - rst pulsed after 4 bytes: no frame_done, busy=1, state returns to SYNC.

Source files
------------

// File: rtl/modbus_rtu_rx_framer.sv
// -----------------------------------------------------------------------------
// modbus_rtu_rx_framer
// Receive-side Modbus RTU framer. Delimits frames on the UART RX byte stream by
// inter-frame silence, buffers the frame bytes and checks the CRC-16/MODBUS
// trailer (reflected poly 0xA001, init 0xFFFF, no final XOR). A good frame,
// trailer included, leaves a running CRC residue of 0x0000.
//
// Ports
//   sys_clk     in   system clock
//   rst         in   asynchronous active-high reset
//   rx_data     in   received byte, valid with rx_vld
//   rx_vld      in   one-cycle byte strobe
//   frame_done  out  one-cycle pulse at the end of each frame
//   frame_ok    out  last frame: good CRC, length >= 4, no overflow (held)
//   crc_err     out  last frame: CRC residue non-zero (held)
//   len_err     out  last frame: shorter than 4 bytes or overflowed (held)
//   frame_len   out  last frame byte count incl. CRC, saturating at MAX_LEN (held)
//   busy        out  high while syncing to the line or receiving a frame
//   rd_addr     in   buffer read address
//   rd_data     out  buffer byte at previous-cycle rd_addr (0 beyond MAX_LEN)
//
// state | meaning
// ------+-----------------------------------------------------------------
// SYNC  | after reset: wait for GAP_CYCLES of silence, bytes are discarded
// IDLE  | line synchronised, waiting for the first byte of a frame
// RECV  | collecting frame bytes until GAP_CYCLES of silence
// DONE  | one cycle, frame_done pulse, status already latched
// -----------------------------------------------------------------------------
module modbus_rtu_rx_framer #(
  parameter int GAP_CYCLES = 200521,
  parameter int MAX_LEN    = 256
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_vld,
  output logic       frame_done,
  output logic       frame_ok,
  output logic       crc_err,
  output logic       len_err,
  output logic [8:0] frame_len,
  output logic       busy,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] GAP_MAX  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [8:0]    LEN_MAX  = 9'(MAX_LEN);

  typedef enum logic [1:0] {SYNC, IDLE, RECV, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   silent_cnt;
  logic            gap_hit;
  logic            start, accept, store;
  logic [15:0]     crc, crc_base, crc_nxt;
  logic [8:0]      len;
  logic            ovf;
  logic [AW-1:0]   waddr;
  logic            lat_crc_err, lat_len_err;
  logic [7:0]      mem [MAX_LEN];

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // gap_hit fires in the last silent cycle so the next state is entered
  // exactly GAP_CYCLES+1 cycles after the last byte.
  assign gap_hit = !rx_vld && (silent_cnt >= GAP_LAST);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)
      silent_cnt <= '0;
    else if (rx_vld)
      silent_cnt <= '0;
    else if (silent_cnt != GAP_MAX)
      silent_cnt <= silent_cnt + CW'(1);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    case (state)
      SYNC: if (gap_hit) state_nxt = IDLE;
      IDLE: if (rx_vld) begin
        state_nxt = RECV;
        start     = 1'b1;
      end
      RECV: begin
        if (rx_vld)       accept    = 1'b1;
        else if (gap_hit) state_nxt = DONE;
      end
      DONE: begin
        if (rx_vld) begin
          state_nxt = RECV;
          start     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  assign busy     = (state == SYNC) || (state == RECV);
  assign store    = start || (accept && (len < LEN_MAX));
  assign waddr    = start ? '0 : len[AW-1:0];
  assign crc_base = start ? 16'hFFFF : crc;
  assign crc_nxt  = crc_upd(crc_base, rx_data);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      crc <= 16'hFFFF;
      len <= '0;
      ovf <= 1'b0;
    end else if (start) begin
      crc <= crc_nxt;
      len <= 9'd1;
      ovf <= 1'b0;
    end else if (accept) begin
      if (len < LEN_MAX) begin
        crc <= crc_nxt;
        len <= len + 9'd1;
      end else begin
        ovf <= 1'b1;
      end
    end
  end

  assign lat_crc_err = (crc != 16'h0000);
  assign lat_len_err = (len < 9'd4) || ovf;

  // Status is captured on entry to DONE so it is valid alongside frame_done.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      frame_len  <= '0;
    end else begin
      frame_done <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        crc_err   <= lat_crc_err;
        len_err   <= lat_len_err;
        frame_ok  <= !lat_crc_err && !lat_len_err;
        frame_len <= len;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (store) mem[waddr] <= rx_data;
  end

  // Registered read; a same-cycle write to the same address returns old data.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)
      rd_data <= 8'h00;
    else if ({1'b0, rd_addr} < LEN_MAX)
      rd_data <= mem[rd_addr[AW-1:0]];
    else
      rd_data <= 8'h00;
  end

endmodule

// File: tb/tb_modbus_rtu_rx_framer.sv
module tb_modbus_rtu_rx_framer;

  localparam int G  = 50;
  localparam int ML = 8;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       frame_done, frame_ok, crc_err, len_err, busy;
  logic [8:0] frame_len;
  logic [7:0] rd_addr, rd_data;

  modbus_rtu_rx_framer #(.GAP_CYCLES(G), .MAX_LEN(ML)) dut (
    .sys_clk(sys_clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld),
    .frame_done(frame_done), .frame_ok(frame_ok), .crc_err(crc_err),
    .len_err(len_err), .frame_len(frame_len), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: line-level view (silence run, frame byte list).
  int          cyc;
  int          quiet;
  bit          synced, in_frame;
  logic [7:0]  fq[$];
  int          ftotal;
  logic [7:0]  mmem[ML];
  bit          mval[ML];
  logic        e_ok, e_crc, e_len;
  logic [8:0]  e_flen;
  bit          erd_v;
  logic [7:0]  erd;
  logic [15:0] ctab[256];

  logic [7:0] good[$];
  logic [7:0] bad[$];
  logic [7:0] fr[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) c = (c >> 8) ^ ctab[(c[7:0] ^ q[i])];
    return c;
  endfunction

  task automatic model_reset();
    synced = 0; in_frame = 0; quiet = 0; ftotal = 0; fq.delete();
    e_ok = 0; e_crc = 0; e_len = 0; e_flen = '0;
    erd_v = 1; erd = 8'h00; cyc = 0;
  endtask

  // One clock cycle: compare the current outputs, drive this cycle's inputs,
  // advance the model, move to the next cycle (#1 after the rising edge).
  task automatic step(input bit v, input logic [7:0] d, input int ra);
    bit done_exp;
    int n;
    if (!synced && quiet >= G) synced = 1;
    done_exp = in_frame && (quiet == G);
    if (done_exp) begin
      n      = (ftotal < ML) ? ftotal : ML;
      e_crc  = (crc_of(fq) != 16'h0000);
      e_len  = (n < 4) || (ftotal > ML);
      e_ok   = !e_crc && !e_len;
      e_flen = 9'(n);
      in_frame = 0;
    end
    chk("frame_done", {15'b0, frame_done}, {15'b0, done_exp});
    chk("busy", {15'b0, busy}, {15'b0, (!synced || in_frame)});
    chk("frame_ok", {15'b0, frame_ok}, {15'b0, e_ok});
    chk("crc_err", {15'b0, crc_err}, {15'b0, e_crc});
    chk("len_err", {15'b0, len_err}, {15'b0, e_len});
    chk("frame_len", {7'b0, frame_len}, {7'b0, e_flen});
    if (erd_v) chk("rd_data", {8'b0, rd_data}, {8'b0, erd});

    rx_vld  = v;
    rx_data = d;
    rd_addr = (ra < 0) ? 8'($urandom_range(0, ML - 1)) : 8'(ra);
    erd_v   = mval[rd_addr];
    erd     = mmem[rd_addr];

    if (v) begin
      if (synced) begin
        if (!in_frame) begin
          in_frame = 1; ftotal = 0; fq.delete();
        end
        ftotal++;
        if (fq.size() < ML) begin
          mmem[fq.size()] = d;
          mval[fq.size()] = 1;
          fq.push_back(d);
        end
      end
      quiet = 0;
    end else if (quiet <= G) begin
      quiet++;
    end
    @(posedge sys_clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'($urandom), -1);
  endtask

  // sp = 0 picks a random spacing per byte.
  task automatic send(input logic [7:0] b[$], input int sp, output int t_last);
    int s;
    t_last = cyc;
    foreach (b[i]) begin
      t_last = cyc;
      step(1, b[i], -1);
      if (i < b.size() - 1) begin
        s = (sp == 0) ? $urandom_range(1, 12) : sp;
        idle(s - 1);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && frame_done !== 1'b1; i++) step(0, 8'h00, -1);
    chk("done_seen", {15'b0, frame_done}, 16'd1);
  endtask

  task automatic readback(input logic [7:0] b[$]);
    for (int a = 0; a < ML; a++) begin
      step(0, 8'h00, a);
      chk("readback", {8'b0, rd_data}, {8'b0, b[a]});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", {15'b0, busy}, 16'd1);
    chk("rst_done", {15'b0, frame_done}, 16'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int t;
    logic [15:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 16'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      ctab[i] = c;
    end
    for (int i = 0; i < ML; i++) begin mval[i] = 0; mmem[i] = 8'h00; end
    good = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    bad  = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0B};
    fr   = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    chk("model_crc", crc_of(fr), 16'h0A84);

    rst = 1'b1; rx_vld = 1'b0; rx_data = 8'h00; rd_addr = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_busy", {15'b0, busy}, 16'd1);
    chk("rst_frame_done", {15'b0, frame_done}, 16'd0);
    chk("rst_frame_ok", {15'b0, frame_ok}, 16'd0);
    chk("rst_crc_err", {15'b0, crc_err}, 16'd0);
    chk("rst_len_err", {15'b0, len_err}, 16'd0);
    chk("rst_frame_len", {7'b0, frame_len}, 16'd0);
    chk("rst_rd_data", {8'b0, rd_data}, 16'd0);
    rst = 1'b0;
    model_reset();

    // Startup sync: bytes at cycles 20 and 50 are discarded, IDLE at 101.
    idle(20);
    step(1, 8'h11, -1);
    idle(29);
    step(1, 8'h22, -1);
    idle(100 - cyc);
    chk("sync_busy_hi", {15'b0, busy}, 16'd1);
    step(0, 8'h00, -1);
    chk("sync_busy_lo", {15'b0, busy}, 16'd0);
    idle(10);

    // Good frame: frame_done exactly 51 cycles after the last byte.
    send(good, 10, t);
    idle(t + 50 - cyc);
    chk("good_early", {15'b0, frame_done}, 16'd0);
    step(0, 8'h00, -1);
    chk("good_done", {15'b0, frame_done}, 16'd1);
    chk("good_ok", {15'b0, frame_ok}, 16'd1);
    chk("good_crc_err", {15'b0, crc_err}, 16'd0);
    chk("good_len_err", {15'b0, len_err}, 16'd0);
    chk("good_len", {7'b0, frame_len}, 16'd8);
    readback(good);
    idle(5);

    // Bad CRC.
    send(bad, 10, t);
    wait_done(G + 10);
    chk("bad_crc_err", {15'b0, crc_err}, 16'd1);
    chk("bad_ok", {15'b0, frame_ok}, 16'd0);
    chk("bad_len", {7'b0, frame_len}, 16'd8);
    idle(5);

    // Short frame.
    fr = '{8'h01, 8'h03};
    send(fr, 3, t);
    wait_done(G + 10);
    chk("short_len_err", {15'b0, len_err}, 16'd1);
    chk("short_ok", {15'b0, frame_ok}, 16'd0);
    chk("short_len", {7'b0, frame_len}, 16'd2);
    idle(5);

    // Overflow: good 8-byte frame plus two extra bytes.
    fr = good;
    fr.push_back(8'hAA);
    fr.push_back(8'h55);
    send(fr, 4, t);
    wait_done(G + 10);
    chk("ovf_len_err", {15'b0, len_err}, 16'd1);
    chk("ovf_crc_err", {15'b0, crc_err}, 16'd0);
    chk("ovf_len", {7'b0, frame_len}, 16'd8);
    chk("ovf_ok", {15'b0, frame_ok}, 16'd0);
    readback(good);
    idle(5);

    // Back-to-back: next frame's first byte lands in the DONE cycle.
    send(bad, 5, t);
    idle(t + 51 - cyc);
    chk("b2b_done", {15'b0, frame_done}, 16'd1);
    send(good, 6, t);
    wait_done(G + 10);
    chk("b2b_ok", {15'b0, frame_ok}, 16'd1);
    chk("b2b_len", {7'b0, frame_len}, 16'd8);
    idle(5);

    // Reset after 4 bytes.
    fr = '{8'h01, 8'h03, 8'h00, 8'h00};
    send(fr, 5, t);
    idle(3);
    do_reset();
    idle(G + 10);
    send(good, 0, t);
    wait_done(G + 10);
    chk("post_rst_ok", {15'b0, frame_ok}, 16'd1);
    idle(5);

    // Randomized frames and inter-frame gaps around the silence threshold.
    for (int f = 0; f < 40; f++) begin
      fr.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) fr.push_back(8'($urandom));
      if ($urandom_range(0, 2) != 0) begin
        c = crc_of(fr);
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
      end
      send(fr, 0, t);
      idle($urandom_range(G - 2, G + 6));
    end
    idle(G + 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
